// File: rtl/acc_pkg.sv
// Shared types and constants for the accelerator-side C-interface responder.
package acc_pkg;

    // Destination register field inside the RISC-V instruction word.
    localparam int RdLsb = 7;
    localparam int RdMsb = 11;

    // Per-request metadata kept while an op is in flight.
    typedef struct packed {
        logic [31:0] hart_id;
        logic [4:0]  rd;
        logic        bypass;
    } acc_c_meta_t;

    // Extract rd from an instruction word.
    function automatic logic [4:0] instr_rd(input logic [31:0] instr);
        return instr[RdMsb:RdLsb];
    endfunction

endpackage

// File: rtl/acc_c_meta_fifo.sv
// In-flight metadata FIFO: synchronous active-high reset, power-of-two depth.
// A push while full is ignored, even if a pop happens in the same cycle.
module acc_c_meta_fifo
    import acc_pkg::*;
#(
    parameter int Depth = 4,
    localparam int PtrW = $clog2(Depth),
    localparam int CntW = $clog2(Depth) + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  acc_c_meta_t     push_data_i,
    input  logic            pop_i,
    output acc_c_meta_t     head_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o
);

    acc_c_meta_t     mem [Depth];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic            push_ok;
    logic            pop_ok;

    assign full_o  = (count_o == CntW'(Depth));
    assign empty_o = (count_o == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign head_o  = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PtrW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PtrW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_o <= count_o + CntW'(1);
                2'b01:   count_o <= count_o - CntW'(1);
                default: count_o <= count_o;
            endcase
        end
    end

    // Storage write.
    always_ff @(posedge clk_i) begin
        // NOTE: storage is not reset; an entry is only read after it has been written.
        if (push_ok) mem[wr_ptr] <= push_data_i;
    end

endmodule

// File: rtl/acc_c_responder.sv
// Accelerator-side C-interface endpoint: registers requests towards one datapath,
// tracks hart_id/rd per op in a metadata FIFO and returns in-order tagged responses.
// Optional feature macro: ACC_C_RESPONDER_ADDR_CHECK_EN (requests for other addresses
// are answered with an error response without reaching the datapath).
module acc_c_responder
    import acc_pkg::*;
#(
    parameter int          DataWidth      = 32,
    parameter int          AddrWidth      = 4,
    parameter int unsigned AccAddr        = 0,
    parameter int          MaxOutstanding = 4,
    localparam int         CntW           = $clog2(MaxOutstanding) + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    // C request
    input  logic                 q_valid_i,
    output logic                 q_ready_o,
    input  logic [AddrWidth-1:0] q_addr_i,
    input  logic [31:0]          q_hart_id_i,
    input  logic [31:0]          q_data_op_i,
    input  logic [DataWidth-1:0] q_data_arga_i,
    input  logic [DataWidth-1:0] q_data_argb_i,
    input  logic [DataWidth-1:0] q_data_argc_i,
    // C response
    output logic                 p_valid_o,
    input  logic                 p_ready_i,
    output logic [DataWidth-1:0] p_data0_o,
    output logic [DataWidth-1:0] p_data1_o,
    output logic                 p_error_o,
    output logic [4:0]           p_rd_o,
    output logic                 p_dual_writeback_o,
    output logic [31:0]          p_hart_id_o,
    // Datapath op
    output logic                 op_valid_o,
    input  logic                 op_ready_i,
    output logic [31:0]          op_instr_o,
    output logic [DataWidth-1:0] op_arga_o,
    output logic [DataWidth-1:0] op_argb_o,
    output logic [DataWidth-1:0] op_argc_o,
    // Datapath result
    input  logic                 res_valid_i,
    output logic                 res_ready_o,
    input  logic [DataWidth-1:0] res_data0_i,
    input  logic [DataWidth-1:0] res_data1_i,
    input  logic                 res_error_i,
    input  logic                 res_dual_i,
    // Status
    output logic [CntW-1:0]      outstanding_o
);

    acc_c_meta_t push_meta;
    acc_c_meta_t meta_head;
    logic        meta_full;
    logic        meta_empty;
    logic        q_hs;
    logic        q_bypass;
    logic        q_fwd;
    logic        out_free;
    logic        res_take;
    logic        res_hs;
    logic        bypass_emit;
    logic        meta_pop;

    // The request register may reload when empty or draining; a full FIFO stalls
    // everything because each accepted request needs a metadata slot.
    assign q_ready_o = (!op_valid_o || op_ready_i) && !meta_full;
    assign q_hs      = q_valid_i && q_ready_o;

`ifdef ACC_C_RESPONDER_ADDR_CHECK_EN
    assign q_bypass    = (q_addr_i != AddrWidth'(AccAddr));
    assign bypass_emit = !meta_empty && meta_head.bypass && out_free;
`else
    logic unused_addr;
    assign unused_addr = ^{q_addr_i, AccAddr};
    assign q_bypass    = 1'b0;
    assign bypass_emit = 1'b0;
`endif

    assign q_fwd = q_hs && !q_bypass;

    assign push_meta.hart_id = q_hart_id_i;
    assign push_meta.rd      = instr_rd(q_data_op_i);
    assign push_meta.bypass  = q_bypass;

    // A result with no matching metadata (e.g. left over from before a reset) is
    // accepted and silently dropped so the datapath never stalls on it.
    assign out_free    = !p_valid_o || p_ready_i;
    assign res_take    = !meta_empty && !meta_head.bypass && out_free;
    assign res_ready_o = meta_empty || res_take;
    assign res_hs      = res_valid_i && res_take;
    assign meta_pop    = res_hs || bypass_emit;

    acc_c_meta_fifo #(
        .Depth(MaxOutstanding)
    ) u_meta_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (q_hs),
        .push_data_i(push_meta),
        .pop_i      (meta_pop),
        .head_o     (meta_head),
        .full_o     (meta_full),
        .empty_o    (meta_empty),
        .count_o    (outstanding_o)
    );

    // Request register: capture forwarded requests, hold until the datapath takes them.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_valid_o <= 1'b0;
            op_instr_o <= '0;
            op_arga_o  <= '0;
            op_argb_o  <= '0;
            op_argc_o  <= '0;
        end else if (!op_valid_o || op_ready_i) begin
            op_valid_o <= q_fwd;
            if (q_fwd) begin
                op_instr_o <= q_data_op_i;
                op_arga_o  <= q_data_arga_i;
                op_argb_o  <= q_data_argb_i;
                op_argc_o  <= q_data_argc_i;
            end
        end
    end

    // Response register: load a datapath result or a bypass error, tagged from the FIFO head.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            p_valid_o          <= 1'b0;
            p_data0_o          <= '0;
            p_data1_o          <= '0;
            p_error_o          <= 1'b0;
            p_rd_o             <= '0;
            p_dual_writeback_o <= 1'b0;
            p_hart_id_o        <= '0;
        end else if (out_free) begin
            p_valid_o <= meta_pop;
            if (res_hs) begin
                p_data0_o          <= res_data0_i;
                p_data1_o          <= res_data1_i;
                p_error_o          <= res_error_i;
                p_dual_writeback_o <= res_dual_i;
                p_rd_o             <= meta_head.rd;
                p_hart_id_o        <= meta_head.hart_id;
            end else if (bypass_emit) begin
                p_data0_o          <= '0;
                p_data1_o          <= '0;
                p_error_o          <= 1'b1;
                p_dual_writeback_o <= 1'b0;
                p_rd_o             <= meta_head.rd;
                p_hart_id_o        <= meta_head.hart_id;
            end
        end
    end

endmodule

// File: tb/tb_acc_c_responder.sv
// Directed self-checking bench for acc_c_responder.
module tb_acc_c_responder;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int MO = 4;
    localparam int CW = 3;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          q_valid_i;
    logic          q_ready_o;
    logic [AW-1:0] q_addr_i;
    logic [31:0]   q_hart_id_i;
    logic [31:0]   q_data_op_i;
    logic [DW-1:0] q_data_arga_i;
    logic [DW-1:0] q_data_argb_i;
    logic [DW-1:0] q_data_argc_i;
    logic          p_valid_o;
    logic          p_ready_i;
    logic [DW-1:0] p_data0_o;
    logic [DW-1:0] p_data1_o;
    logic          p_error_o;
    logic [4:0]    p_rd_o;
    logic          p_dual_writeback_o;
    logic [31:0]   p_hart_id_o;
    logic          op_valid_o;
    logic          op_ready_i;
    logic [31:0]   op_instr_o;
    logic [DW-1:0] op_arga_o;
    logic [DW-1:0] op_argb_o;
    logic [DW-1:0] op_argc_o;
    logic          res_valid_i;
    logic          res_ready_o;
    logic [DW-1:0] res_data0_i;
    logic [DW-1:0] res_data1_i;
    logic          res_error_i;
    logic          res_dual_i;
    logic [CW-1:0] outstanding_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    acc_c_responder #(
        .DataWidth(DW), .AddrWidth(AW), .AccAddr(0), .MaxOutstanding(MO)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .q_valid_i(q_valid_i), .q_ready_o(q_ready_o), .q_addr_i(q_addr_i),
        .q_hart_id_i(q_hart_id_i), .q_data_op_i(q_data_op_i),
        .q_data_arga_i(q_data_arga_i), .q_data_argb_i(q_data_argb_i), .q_data_argc_i(q_data_argc_i),
        .p_valid_o(p_valid_o), .p_ready_i(p_ready_i), .p_data0_o(p_data0_o), .p_data1_o(p_data1_o),
        .p_error_o(p_error_o), .p_rd_o(p_rd_o), .p_dual_writeback_o(p_dual_writeback_o),
        .p_hart_id_o(p_hart_id_o),
        .op_valid_o(op_valid_o), .op_ready_i(op_ready_i), .op_instr_o(op_instr_o),
        .op_arga_o(op_arga_o), .op_argb_o(op_argb_o), .op_argc_o(op_argc_o),
        .res_valid_i(res_valid_i), .res_ready_o(res_ready_o), .res_data0_i(res_data0_i),
        .res_data1_i(res_data1_i), .res_error_i(res_error_i), .res_dual_i(res_dual_i),
        .outstanding_o(outstanding_o)
    );

    function automatic logic [31:0] mk_instr(input int rd);
        return 32'((rd & 31) << 7) | 32'h33;
    endfunction

    task automatic drive_req(input int addr, input int hart, input int rd, input int arga);
        q_valid_i     = 1'b1;
        q_addr_i      = AW'(addr);
        q_hart_id_i   = 32'(hart);
        q_data_op_i   = mk_instr(rd);
        q_data_arga_i = 32'(arga);
        q_data_argb_i = 32'(arga + 1);
        q_data_argc_i = 32'(arga + 2);
    endtask

    task automatic drive_res(input logic v, input int d0, input int d1, input logic err, input logic dual);
        res_valid_i = v;
        res_data0_i = 32'(d0);
        res_data1_i = 32'(d1);
        res_error_i = err;
        res_dual_i  = dual;
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        if (p_valid_o !== 1'b0) begin bad++; $display("FAIL reset_p_valid got=%0b want=0", p_valid_o); end
        total++;
        if (op_valid_o !== 1'b0) begin bad++; $display("FAIL reset_op_valid got=%0b want=0", op_valid_o); end
        total++;
        if (outstanding_o !== 3'd0) begin bad++; $display("FAIL reset_outstanding got=%0d want=0", outstanding_o); end
        total++;
        if (q_ready_o !== 1'b1) begin bad++; $display("FAIL reset_q_ready got=%0b want=1", q_ready_o); end
        total++;
        if ({p_data0_o, op_instr_o, p_hart_id_o} !== 96'h0) begin
            bad++; $display("FAIL reset_data got=%h/%h/%h want=0", p_data0_o, op_instr_o, p_hart_id_o);
        end
        total++;
    endtask

    task automatic test_single_op;
        @(negedge clk_i);
        drive_req(0, 3, 5, 32'h10);
        #1;
        if (q_ready_o !== 1'b1) begin bad++; $display("FAIL single_q_ready got=%0b want=1", q_ready_o); end
        total++;
        @(negedge clk_i);
        q_valid_i = 1'b0;
        if ({op_valid_o, op_instr_o, op_arga_o, outstanding_o} !== {1'b1, 32'h2B3, 32'h10, 3'd1}) begin
            bad++; $display("FAIL single_op_reg got v=%0b i=%h a=%h o=%0d want v=1 i=2b3 a=10 o=1",
                            op_valid_o, op_instr_o, op_arga_o, outstanding_o);
        end
        total++;
        @(negedge clk_i);
        if (op_valid_o !== 1'b0) begin bad++; $display("FAIL single_op_drained got=%0b want=0", op_valid_o); end
        total++;
        @(negedge clk_i);
        @(negedge clk_i);
        drive_res(1'b1, 32'h20, 0, 1'b0, 1'b0);
        #1;
        if ({res_ready_o, p_valid_o} !== 2'b10) begin
            bad++; $display("FAIL single_res_cycle got rr=%0b pv=%0b want rr=1 pv=0", res_ready_o, p_valid_o);
        end
        total++;
        @(negedge clk_i);
        res_valid_i = 1'b0;
        if ({p_valid_o, p_data0_o, p_rd_o, p_hart_id_o, p_error_o, outstanding_o} !==
            {1'b1, 32'h20, 5'd5, 32'd3, 1'b0, 3'd0}) begin
            bad++; $display("FAIL single_resp got v=%0b d=%h rd=%0d h=%0d e=%0b o=%0d want v=1 d=20 rd=5 h=3 e=0 o=0",
                            p_valid_o, p_data0_o, p_rd_o, p_hart_id_o, p_error_o, outstanding_o);
        end
        total++;
        @(negedge clk_i);
        if (p_valid_o !== 1'b0) begin bad++; $display("FAIL single_resp_once got=%0b want=0", p_valid_o); end
        total++;
    endtask

    task automatic test_fill;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            drive_req(0, 10 + i, i + 1, i);
            #1;
            if (q_ready_o !== 1'b1) begin bad++; $display("FAIL fill_accept%0d got=%0b want=1", i, q_ready_o); end
            total++;
        end
        @(negedge clk_i);
        drive_req(0, 14, 5, 4);
        drive_res(1'b1, 32'h100, 0, 1'b0, 1'b0);
        #1;
        if ({q_ready_o, outstanding_o, res_ready_o} !== {1'b0, 3'd4, 1'b1}) begin
            bad++; $display("FAIL fill_full got qr=%0b o=%0d rr=%0b want qr=0 o=4 rr=1",
                            q_ready_o, outstanding_o, res_ready_o);
        end
        total++;
        @(negedge clk_i);
        res_valid_i = 1'b0;
        #1;
        if ({q_ready_o, outstanding_o, p_valid_o, p_hart_id_o, p_rd_o, p_data0_o} !==
            {1'b1, 3'd3, 1'b1, 32'd10, 5'd1, 32'h100}) begin
            bad++; $display("FAIL fill_pop got qr=%0b o=%0d pv=%0b h=%0d rd=%0d d=%h want qr=1 o=3 pv=1 h=10 rd=1 d=100",
                            q_ready_o, outstanding_o, p_valid_o, p_hart_id_o, p_rd_o, p_data0_o);
        end
        total++;
        @(negedge clk_i);
        q_valid_i = 1'b0;
        if ({outstanding_o, op_valid_o, op_instr_o} !== {3'd4, 1'b1, mk_instr(5)}) begin
            bad++; $display("FAIL fill_fifth got o=%0d ov=%0b i=%h want o=4 ov=1 i=%h",
                            outstanding_o, op_valid_o, op_instr_o, mk_instr(5));
        end
        total++;
        for (int j = 0; j < 4; j++) begin
            drive_res(1'b1, 32'h200 + j, 0, 1'b0, 1'b0);
            @(negedge clk_i);
            if ({p_valid_o, p_hart_id_o, p_rd_o, p_data0_o} !== {1'b1, 32'(11 + j), 5'(j + 2), 32'(32'h200 + j)}) begin
                bad++; $display("FAIL fill_drain%0d got v=%0b h=%0d rd=%0d d=%h want v=1 h=%0d rd=%0d d=%h",
                                j, p_valid_o, p_hart_id_o, p_rd_o, p_data0_o, 11 + j, j + 2, 32'h200 + j);
            end
            total++;
        end
        res_valid_i = 1'b0;
        @(negedge clk_i);
        if ({p_valid_o, outstanding_o} !== {1'b0, 3'd0}) begin
            bad++; $display("FAIL fill_empty got pv=%0b o=%0d want pv=0 o=0", p_valid_o, outstanding_o);
        end
        total++;
    endtask

    task automatic test_backpressure;
        @(negedge clk_i);
        drive_req(0, 20, 6, 1);
        @(negedge clk_i);
        drive_req(0, 21, 7, 2);
        @(negedge clk_i);
        q_valid_i = 1'b0;
        p_ready_i = 1'b0;
        drive_res(1'b1, 32'hA0, 32'hA1, 1'b1, 1'b1);
        #1;
        if (res_ready_o !== 1'b1) begin bad++; $display("FAIL bp_first_res got=%0b want=1", res_ready_o); end
        total++;
        @(negedge clk_i);
        drive_res(1'b1, 32'hB0, 32'hB1, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            #1;
            if ({p_valid_o, p_data0_o, p_data1_o, p_rd_o, p_hart_id_o, p_error_o, p_dual_writeback_o, res_ready_o} !==
                {1'b1, 32'hA0, 32'hA1, 5'd6, 32'd20, 1'b1, 1'b1, 1'b0}) begin
                bad++; $display("FAIL bp_hold%0d got v=%0b d0=%h d1=%h rd=%0d h=%0d e=%0b du=%0b rr=%0b want 1 a0 a1 6 20 1 1 0",
                                k, p_valid_o, p_data0_o, p_data1_o, p_rd_o, p_hart_id_o, p_error_o,
                                p_dual_writeback_o, res_ready_o);
            end
            total++;
            @(negedge clk_i);
        end
        if (outstanding_o !== 3'd1) begin bad++; $display("FAIL bp_outstanding got=%0d want=1", outstanding_o); end
        total++;
        p_ready_i = 1'b1;
        #1;
        if (res_ready_o !== 1'b1) begin bad++; $display("FAIL bp_release_rr got=%0b want=1", res_ready_o); end
        total++;
        @(negedge clk_i);
        res_valid_i = 1'b0;
        if ({p_valid_o, p_data0_o, p_data1_o, p_rd_o, p_hart_id_o, p_error_o, p_dual_writeback_o} !==
            {1'b1, 32'hB0, 32'hB1, 5'd7, 32'd21, 1'b0, 1'b0}) begin
            bad++; $display("FAIL bp_second got v=%0b d0=%h rd=%0d h=%0d e=%0b du=%0b want 1 b0 7 21 0 0",
                            p_valid_o, p_data0_o, p_rd_o, p_hart_id_o, p_error_o, p_dual_writeback_o);
        end
        total++;
        @(negedge clk_i);
        if ({p_valid_o, outstanding_o} !== {1'b0, 3'd0}) begin
            bad++; $display("FAIL bp_done got pv=%0b o=%0d want pv=0 o=0", p_valid_o, outstanding_o);
        end
        total++;
    endtask

    task automatic test_streaming;
        logic          pend_valid = 1'b0;
        logic [DW-1:0] pend_data  = '0;
        int            n_resp     = 0;
        int            first_c    = -1;
        int            last_c     = -1;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk_i);
            if (p_valid_o === 1'b1) begin
                if (n_resp >= 16 || {p_hart_id_o, p_rd_o, p_data0_o} !==
                    {32'(100 + n_resp), 5'(n_resp + 1), 32'(n_resp * 3 + 1)}) begin
                    bad++; $display("FAIL stream_resp%0d got h=%0d rd=%0d d=%0d want h=%0d rd=%0d d=%0d",
                                    n_resp, p_hart_id_o, p_rd_o, p_data0_o, 100 + n_resp, n_resp + 1, n_resp * 3 + 1);
                end
                total++;
                if (n_resp == 0) first_c = c;
                last_c = c;
                n_resp++;
            end
            drive_res(pend_valid, int'(pend_data), 0, 1'b0, 1'b0);
            pend_valid = op_valid_o;
            pend_data  = op_arga_o + 32'd1;
            if (c < 16) drive_req(0, 100 + c, c + 1, c * 3);
            else        q_valid_i = 1'b0;
            #1;
            if (c < 16) begin
                if (q_ready_o !== 1'b1) begin bad++; $display("FAIL stream_q_ready%0d got=%0b want=1", c, q_ready_o); end
                total++;
            end
        end
        res_valid_i = 1'b0;
        if (n_resp !== 16 || last_c - first_c !== 15) begin
            bad++; $display("FAIL stream_rate got n=%0d span=%0d want n=16 span=15", n_resp, last_c - first_c);
        end
        total++;
    endtask

    task automatic test_reset_midflight;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            drive_req(0, 40 + i, i + 8, i);
        end
        @(negedge clk_i);
        q_valid_i = 1'b0;
        p_ready_i = 1'b0;
        drive_res(1'b1, 32'h55, 0, 1'b0, 1'b0);
        @(negedge clk_i);
        res_valid_i = 1'b0;
        if ({p_valid_o, outstanding_o} !== {1'b1, 3'd3}) begin
            bad++; $display("FAIL rst_pre got pv=%0b o=%0d want pv=1 o=3", p_valid_o, outstanding_o);
        end
        total++;
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i     = 1'b0;
        p_ready_i = 1'b1;
        #1;
        if ({p_valid_o, outstanding_o, op_valid_o, p_data0_o} !== {1'b0, 3'd0, 1'b0, 32'h0}) begin
            bad++; $display("FAIL rst_mid got pv=%0b o=%0d ov=%0b d=%h want 0 0 0 0",
                            p_valid_o, outstanding_o, op_valid_o, p_data0_o);
        end
        total++;
        drive_res(1'b1, 32'h66, 0, 1'b0, 1'b0);
        #1;
        if (res_ready_o !== 1'b1) begin bad++; $display("FAIL rst_late_rr got=%0b want=1", res_ready_o); end
        total++;
        @(negedge clk_i);
        res_valid_i = 1'b0;
        if ({p_valid_o, outstanding_o} !== {1'b0, 3'd0}) begin
            bad++; $display("FAIL rst_late_drop got pv=%0b o=%0d want 0 0", p_valid_o, outstanding_o);
        end
        total++;
        @(negedge clk_i);
        if (p_valid_o !== 1'b0) begin bad++; $display("FAIL rst_no_resp got=%0b want=0", p_valid_o); end
        total++;
    endtask

`ifdef ACC_C_RESPONDER_ADDR_CHECK_EN
    task automatic test_addr_check;
        logic [DW-1:0] exp_data [3] = '{32'd1, 32'd0, 32'd7};
        logic          exp_err  [3] = '{1'b0, 1'b1, 1'b0};
        int            addrs    [3] = '{0, 1, 0};
        logic          pend_valid = 1'b0;
        logic [DW-1:0] pend_data  = '0;
        int            n_resp     = 0;
        int            n_ops      = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk_i);
            if (p_valid_o === 1'b1) begin
                if (n_resp >= 3 || {p_hart_id_o, p_rd_o, p_data0_o, p_error_o, p_dual_writeback_o} !==
                    {32'(60 + n_resp), 5'(n_resp + 1), exp_data[n_resp], exp_err[n_resp], 1'b0}) begin
                    bad++; $display("FAIL addr_resp%0d got h=%0d rd=%0d d=%0d e=%0b du=%0b",
                                    n_resp, p_hart_id_o, p_rd_o, p_data0_o, p_error_o, p_dual_writeback_o);
                end
                total++;
                n_resp++;
            end
            if (op_valid_o === 1'b1) n_ops++;
            drive_res(pend_valid, int'(pend_data), 0, 1'b0, 1'b0);
            pend_valid = op_valid_o;
            pend_data  = op_arga_o + 32'd1;
            if (c < 3) drive_req(addrs[c], 60 + c, c + 1, c * 3);
            else       q_valid_i = 1'b0;
        end
        res_valid_i = 1'b0;
        if (n_resp !== 3 || n_ops !== 2) begin
            bad++; $display("FAIL addr_counts got resp=%0d ops=%0d want resp=3 ops=2", n_resp, n_ops);
        end
        total++;
    endtask
`else
    task automatic test_addr_check;
        @(negedge clk_i);
        drive_req(5, 70, 9, 0);
        #1;
        if (q_ready_o !== 1'b1) begin bad++; $display("FAIL addr_ign_q_ready got=%0b want=1", q_ready_o); end
        total++;
        @(negedge clk_i);
        q_valid_i = 1'b0;
        if ({op_valid_o, op_instr_o} !== {1'b1, mk_instr(9)}) begin
            bad++; $display("FAIL addr_ign_op got ov=%0b i=%h want ov=1 i=%h", op_valid_o, op_instr_o, mk_instr(9));
        end
        total++;
        @(negedge clk_i);
        drive_res(1'b1, 32'h77, 0, 1'b0, 1'b0);
        @(negedge clk_i);
        res_valid_i = 1'b0;
        if ({p_valid_o, p_error_o, p_data0_o, p_hart_id_o, p_rd_o} !== {1'b1, 1'b0, 32'h77, 32'd70, 5'd9}) begin
            bad++; $display("FAIL addr_ign_resp got v=%0b e=%0b d=%h h=%0d rd=%0d want 1 0 77 70 9",
                            p_valid_o, p_error_o, p_data0_o, p_hart_id_o, p_rd_o);
        end
        total++;
        @(negedge clk_i);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i       = 1'b1;
        q_valid_i   = 1'b0;
        q_addr_i    = '0;
        q_hart_id_i = '0;
        q_data_op_i = '0;
        q_data_arga_i = '0;
        q_data_argb_i = '0;
        q_data_argc_i = '0;
        p_ready_i   = 1'b1;
        op_ready_i  = 1'b1;
        drive_res(1'b0, 0, 0, 1'b0, 1'b0);

        test_reset();
        test_single_op();
        test_fill();
        test_backpressure();
        test_streaming();
        test_reset_midflight();
        test_addr_check();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
